// File: rtl/esm_pkg.sv
// Shared ESM control-message definitions: magic number, module ids, message types,
// decoder state encoding, header layout and a small pulse-count helper.
package esm_pkg;

  localparam logic [31:0] esm_control_magic_num = 32'hE5C0_F16A;

  localparam logic [7:0] esm_module_id_dwell       = 8'h01;
  localparam logic [7:0] esm_module_id_ad9361      = 8'h02;
  localparam logic [7:0] esm_module_id_channelizer = 8'h03;

  localparam logic [7:0] esm_control_message_type_dwell_entry  = 8'h01;
  localparam logic [7:0] esm_control_message_type_ad9361_write = 8'h02;
  localparam logic [7:0] esm_control_message_type_channel_mask = 8'h03;

  typedef enum logic [2:0] {
    S_MAGIC,
    S_SEQ,
    S_HEADER,
    S_PAD,
    S_PAYLOAD,
    S_DRAIN
  } esm_decoder_state_t;

  typedef struct packed {
    logic [31:0] magic;
    logic [31:0] seq;
    logic [7:0]  module_id;
    logic [7:0]  message_type;
  } esm_config_header_t;

  // Number of asserted error pulses in one cycle; errors can coincide and each one counts.
  function automatic logic [2:0] count_pulses(input logic [3:0] pulses);
    return {2'b00, pulses[0]} + {2'b00, pulses[1]} + {2'b00, pulses[2]} + {2'b00, pulses[3]};
  endfunction

endpackage

// File: rtl/esm_config_sat_counter.sv
// Saturating up-counter with a multi-unit increment; sticks at all-ones.
module esm_config_sat_counter #(
  parameter int WIDTH = 16,
  parameter int INC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] sum;

  assign inc_ext = {{(WIDTH + 1 - INC_W){1'b0}}, inc};
  assign sum     = {1'b0, count} + inc_ext;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= MAX_COUNT;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/esm_config_decoder.sv
// ESM control-message stream decoder: validates magic/length, strips the 4-word header and
// broadcasts payload words. Optional sequence checking is built when ESM_CONFIG_SEQ_CHECK_EN is defined.
module esm_config_decoder
  import esm_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH    = 32,
  parameter logic [31:0] MAGIC_NUM         = esm_control_magic_num,
  parameter int          MAX_PAYLOAD_WORDS = 255
) (
  input  logic                      S_axis_clk,
  input  logic                      S_axis_resetn,
  output logic                      S_axis_ready,
  input  logic                      S_axis_valid,
  input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic                      S_axis_last,
  output logic                      Cfg_valid,
  output logic                      Cfg_first,
  output logic                      Cfg_last,
  output logic [7:0]                Cfg_module_id,
  output logic [7:0]                Cfg_message_type,
  output logic [7:0]                Cfg_word_index,
  output logic [AXI_DATA_WIDTH-1:0] Cfg_data,
  output logic                      Msg_done,
  output logic                      Err_magic,
  output logic                      Err_short,
  output logic                      Err_overflow,
  output logic                      Err_seq,
  output logic [15:0]               Msg_count,
  output logic [15:0]               Err_count
);

  localparam logic [7:0] MAX_INDEX = 8'(MAX_PAYLOAD_WORDS);

  esm_decoder_state_t state_q, state_d;

  logic       ready_q;
  logic       accept;
  logic [7:0] index_q, index_d;
  logic [7:0] hdr_module_q, hdr_module_d;
  logic [7:0] hdr_type_q, hdr_type_d;

  logic                      cfg_valid_d, cfg_first_d, cfg_last_d;
  logic [7:0]                cfg_module_d, cfg_type_d, cfg_index_d;
  logic [AXI_DATA_WIDTH-1:0] cfg_data_d;
  logic                      msg_done_d;
  logic                      err_magic_d, err_short_d, err_overflow_d, err_seq_d;
  logic [2:0]                err_inc;
  logic [2:0]                msg_inc;

  assign accept       = S_axis_valid && ready_q;
  assign S_axis_ready = ready_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    index_d        = index_q;
    hdr_module_d   = hdr_module_q;
    hdr_type_d     = hdr_type_q;
    cfg_valid_d    = 1'b0;
    cfg_first_d    = 1'b0;
    cfg_last_d     = 1'b0;
    cfg_module_d   = Cfg_module_id;
    cfg_type_d     = Cfg_message_type;
    cfg_index_d    = Cfg_word_index;
    cfg_data_d     = Cfg_data;
    msg_done_d     = 1'b0;
    err_magic_d    = 1'b0;
    err_short_d    = 1'b0;
    err_overflow_d = 1'b0;

    if (accept) begin
      unique case (state_q)
        S_MAGIC: begin
          if (S_axis_data == MAGIC_NUM && !S_axis_last) begin
            state_d = S_SEQ;
          end else begin
            err_magic_d = 1'b1;
            state_d     = S_axis_last ? S_MAGIC : S_DRAIN;
          end
        end
        S_SEQ: begin
          err_short_d = S_axis_last;
          state_d     = S_axis_last ? S_MAGIC : S_HEADER;
        end
        S_HEADER: begin
          hdr_module_d = S_axis_data[31:24];
          hdr_type_d   = S_axis_data[23:16];
          err_short_d  = S_axis_last;
          state_d      = S_axis_last ? S_MAGIC : S_PAD;
        end
        S_PAD: begin
          index_d     = '0;
          err_short_d = S_axis_last;
          state_d     = S_axis_last ? S_MAGIC : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (index_q == MAX_INDEX) begin
            // Oversized message: drop the rest; without Cfg_last consumers discard it.
            err_overflow_d = 1'b1;
            state_d        = S_axis_last ? S_MAGIC : S_DRAIN;
          end else begin
            cfg_valid_d  = 1'b1;
            cfg_first_d  = (index_q == 8'd0);
            cfg_last_d   = S_axis_last;
            cfg_module_d = hdr_module_q;
            cfg_type_d   = hdr_type_q;
            cfg_index_d  = index_q;
            cfg_data_d   = S_axis_data;
            index_d      = index_q + 8'd1;
            if (S_axis_last) begin
              msg_done_d = 1'b1;
              state_d    = S_MAGIC;
            end
          end
        end
        S_DRAIN: begin
          if (S_axis_last) state_d = S_MAGIC;
        end
        default: state_d = S_MAGIC;
      endcase
    end
  end

`ifdef ESM_CONFIG_SEQ_CHECK_EN
  logic [AXI_DATA_WIDTH-1:0] last_seq_q;
  logic                      have_seq_q;
  logic                      seq_bad_q;

  // The expectation follows every message that got past its magic word, delivered or not.
  always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
    if (!S_axis_resetn) begin
      last_seq_q <= '0;
      have_seq_q <= 1'b0;
      seq_bad_q  <= 1'b0;
    end else if (accept && state_q == S_SEQ) begin
      seq_bad_q  <= have_seq_q && (S_axis_data != last_seq_q + AXI_DATA_WIDTH'(1));
      last_seq_q <= S_axis_data;
      have_seq_q <= 1'b1;
    end
  end

  assign err_seq_d = accept && (state_q == S_HEADER) && seq_bad_q;
`else
  assign err_seq_d = 1'b0;
`endif

  always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
    if (!S_axis_resetn) begin
      state_q          <= S_MAGIC;
      ready_q          <= 1'b0;
      index_q          <= '0;
      hdr_module_q     <= '0;
      hdr_type_q       <= '0;
      Cfg_valid        <= 1'b0;
      Cfg_first        <= 1'b0;
      Cfg_last         <= 1'b0;
      Cfg_module_id    <= '0;
      Cfg_message_type <= '0;
      Cfg_word_index   <= '0;
      Cfg_data         <= '0;
      Msg_done         <= 1'b0;
      Err_magic        <= 1'b0;
      Err_short        <= 1'b0;
      Err_overflow     <= 1'b0;
      Err_seq          <= 1'b0;
    end else begin
      state_q          <= state_d;
      ready_q          <= 1'b1;
      index_q          <= index_d;
      hdr_module_q     <= hdr_module_d;
      hdr_type_q       <= hdr_type_d;
      Cfg_valid        <= cfg_valid_d;
      Cfg_first        <= cfg_first_d;
      Cfg_last         <= cfg_last_d;
      Cfg_module_id    <= cfg_module_d;
      Cfg_message_type <= cfg_type_d;
      Cfg_word_index   <= cfg_index_d;
      Cfg_data         <= cfg_data_d;
      Msg_done         <= msg_done_d;
      Err_magic        <= err_magic_d;
      Err_short        <= err_short_d;
      Err_overflow     <= err_overflow_d;
      Err_seq          <= err_seq_d;
    end
  end

  assign err_inc = count_pulses({err_magic_d, err_short_d, err_overflow_d, err_seq_d});
  assign msg_inc = {2'b00, msg_done_d};

  esm_config_sat_counter #(.WIDTH(16), .INC_W(3)) u_msg_counter (
    .clk   (S_axis_clk),
    .rst_n (S_axis_resetn),
    .inc   (msg_inc),
    .count (Msg_count)
  );

  esm_config_sat_counter #(.WIDTH(16), .INC_W(3)) u_err_counter (
    .clk   (S_axis_clk),
    .rst_n (S_axis_resetn),
    .inc   (err_inc),
    .count (Err_count)
  );

endmodule

// File: tb/tb_esm_config_decoder.sv
// Self-checking bench for esm_config_decoder: message-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized messages with random gaps.
`timescale 1ns/1ps
module tb_esm_config_decoder;
  import esm_pkg::*;

  localparam int MAXW = 255;
`ifdef ESM_CONFIG_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        S_axis_clk = 1'b0;
  logic        S_axis_resetn = 1'b1;
  logic        S_axis_ready;
  logic        S_axis_valid = 1'b0;
  logic [31:0] S_axis_data = '0;
  logic        S_axis_last = 1'b0;
  logic        Cfg_valid, Cfg_first, Cfg_last;
  logic [7:0]  Cfg_module_id, Cfg_message_type, Cfg_word_index;
  logic [31:0] Cfg_data;
  logic        Msg_done, Err_magic, Err_short, Err_overflow, Err_seq;
  logic [15:0] Msg_count, Err_count;

  always #5 S_axis_clk = ~S_axis_clk;

  esm_config_decoder dut (
    .S_axis_clk       (S_axis_clk),
    .S_axis_resetn    (S_axis_resetn),
    .S_axis_ready     (S_axis_ready),
    .S_axis_valid     (S_axis_valid),
    .S_axis_data      (S_axis_data),
    .S_axis_last      (S_axis_last),
    .Cfg_valid        (Cfg_valid),
    .Cfg_first        (Cfg_first),
    .Cfg_last         (Cfg_last),
    .Cfg_module_id    (Cfg_module_id),
    .Cfg_message_type (Cfg_message_type),
    .Cfg_word_index   (Cfg_word_index),
    .Cfg_data         (Cfg_data),
    .Msg_done         (Msg_done),
    .Err_magic        (Err_magic),
    .Err_short        (Err_short),
    .Err_overflow     (Err_overflow),
    .Err_seq          (Err_seq),
    .Msg_count        (Msg_count),
    .Err_count        (Err_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks word position inside the current message.
  int          m_pos, m_k;
  bit          m_drop, m_ready;
  logic [7:0]  m_mod, m_type;
  logic [31:0] m_prev_seq;
  bit          m_have_seq, m_seq_bad;
  bit          e_valid, e_first, e_last, e_done, e_em, e_es, e_eo, e_eseq;
  logic [7:0]  e_mod, e_type, e_idx;
  logic [31:0] e_data;
  int          e_msgs, e_errs;

  task automatic model_reset();
    m_pos = 0; m_drop = 0; m_ready = 0; m_mod = '0; m_type = '0;
    m_prev_seq = '0; m_have_seq = 0; m_seq_bad = 0;
    {e_valid, e_first, e_last, e_done, e_em, e_es, e_eo, e_eseq} = '0;
    e_mod = '0; e_type = '0; e_idx = '0; e_data = '0; e_msgs = 0; e_errs = 0;
  endtask

  task automatic model_step(input bit acc, input logic [31:0] d, input bit l);
    {e_valid, e_first, e_last, e_done, e_em, e_es, e_eo, e_eseq} = '0;
    if (!acc) return;
    if (m_pos == 0) begin
      m_drop = 0;
      if (d != esm_control_magic_num || l) begin e_em = 1; m_drop = 1; end
    end else if (!m_drop) begin
      if (m_pos <= 3 && l) e_es = 1;
      if (m_pos == 1) begin
        m_seq_bad  = m_have_seq && (d != m_prev_seq + 32'd1);
        m_prev_seq = d;
        m_have_seq = 1;
      end
      if (m_pos == 2) begin
        m_mod = d[31:24]; m_type = d[23:16];
        if (SEQ_EN) e_eseq = m_seq_bad;
      end
      if (m_pos >= 4) begin
        m_k = m_pos - 4;
        if (m_k < MAXW) begin
          e_valid = 1; e_first = (m_k == 0); e_last = l; e_done = l;
          e_idx = 8'(m_k); e_data = d; e_mod = m_mod; e_type = m_type;
        end else begin
          e_eo = 1; m_drop = 1;
        end
      end
    end
    e_errs = e_errs + int'(e_em) + int'(e_es) + int'(e_eo) + int'(e_eseq);
    if (e_errs > 65535) e_errs = 65535;
    if (e_done && e_msgs < 65535) e_msgs++;
    m_pos = l ? 0 : m_pos + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge S_axis_clk or negedge S_axis_resetn);
      if (!S_axis_resetn) model_reset();
      else begin
        model_step(S_axis_valid && m_ready, S_axis_data, S_axis_last);
        m_ready = 1;
      end
    end
  end

  // Observed pulse tallies for the directed literal checks.
  int obs_valid = 0, obs_done = 0, obs_em = 0, obs_es = 0, obs_eo = 0, obs_eseq = 0;
  logic [7:0]  obs_idx;
  logic [31:0] obs_data;
  bit          obs_fl;

  initial forever begin
    @(negedge S_axis_clk);
    check("ready", S_axis_ready, m_ready);
    check("cfg_ctrl", {Cfg_valid, Cfg_first, Cfg_last, Msg_done}, {e_valid, e_first, e_last, e_done});
    check("errors", {Err_magic, Err_short, Err_overflow, Err_seq}, {e_em, e_es, e_eo, e_eseq});
    check("cfg_fields", {Cfg_module_id, Cfg_message_type, Cfg_word_index, Cfg_data},
          {e_mod, e_type, e_idx, e_data});
    check("msg_count", Msg_count, 16'(e_msgs));
    check("err_count", Err_count, 16'(e_errs));
    if (Cfg_valid) begin
      obs_valid++; obs_idx = Cfg_word_index; obs_data = Cfg_data; obs_fl = Cfg_first && Cfg_last;
    end
    if (Msg_done) obs_done++;
    if (Err_magic) obs_em++;
    if (Err_short) obs_es++;
    if (Err_overflow) obs_eo++;
    if (Err_seq) obs_eseq++;
  end

  // Stimulus helpers.
  logic [31:0] wq[$];
  bit          gap_en = 0;
  logic [31:0] next_seq = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge S_axis_clk); #1; end
  endtask

  task automatic idle(input int n);
    S_axis_valid = 0; S_axis_last = 0;
    tick(n);
  endtask

  task automatic send_word(input logic [31:0] d, input bit l);
    if (gap_en) while ($urandom_range(0, 2) == 0) begin S_axis_valid = 0; tick(1); end
    S_axis_valid = 1; S_axis_data = d; S_axis_last = l;
    for (int t = 0; ; t++) begin
      if (S_axis_ready) begin tick(1); break; end
      if (t > 50) begin check("ready_wait", S_axis_ready, 1'b1); break; end
      tick(1);
    end
    S_axis_valid = 0; S_axis_last = 0;
  endtask

  task automatic send_queue(input int upto);
    for (int i = 0; i < upto && i < wq.size(); i++) send_word(wq[i], i == wq.size() - 1);
  endtask

  task automatic build_msg(input logic [31:0] magic, input logic [7:0] mod, input logic [7:0] typ,
                           input int npay);
    esm_config_header_t h;
    h.magic = magic; h.seq = next_seq; h.module_id = mod; h.message_type = typ;
    next_seq = next_seq + 1;
    wq.delete();
    wq.push_back(h.magic);
    wq.push_back(h.seq);
    wq.push_back({h.module_id, h.message_type, 16'h0000});
    wq.push_back(32'hDEADBEEF);
    for (int i = 0; i < npay; i++) wq.push_back($urandom);
  endtask

  int b_valid, b_done, b_em, b_es, b_eo, b_eseq;
  task automatic mark();
    b_valid = obs_valid; b_done = obs_done; b_em = obs_em; b_es = obs_es; b_eo = obs_eo; b_eseq = obs_eseq;
  endtask

  initial begin
    #1 S_axis_resetn = 0;
    tick(3);
    check("rst_msg_count", Msg_count, 16'd0);
    check("rst_ready", S_axis_ready, 1'b0);
    S_axis_resetn = 1;
    tick(2);

    // Minimal message: one payload word.
    mark();
    wq.delete();
    wq.push_back(esm_control_magic_num); wq.push_back(32'd0); wq.push_back(32'h0);
    wq.push_back(32'hDEADBEEF); wq.push_back(32'h0100_0000);
    next_seq = 1;
    send_queue(wq.size());
    idle(3);
    check("t1_valid_cnt", obs_valid - b_valid, 1);
    check("t1_first_last", obs_fl, 1'b1);
    check("t1_data", obs_data, 32'h0100_0000);
    check("t1_done_cnt", obs_done - b_done, 1);
    check("t1_msg_count", Msg_count, 16'd1);

    // Dwell entry, 9 payload words, gapped valid.
    mark();
    gap_en = 1;
    build_msg(esm_control_magic_num, esm_module_id_dwell, esm_control_message_type_dwell_entry, 9);
    send_queue(wq.size());
    gap_en = 0;
    idle(3);
    check("t2_valid_cnt", obs_valid - b_valid, 9);
    check("t2_last_idx", obs_idx, 8'd8);
    check("t2_done_cnt", obs_done - b_done, 1);
    check("t2_module", {Cfg_module_id, Cfg_message_type}, 16'h0101);

    // Bad magic in a 6-word message, followed back-to-back by a good one.
    mark();
    wq.delete();
    wq.push_back(32'h1234_5678);
    for (int i = 0; i < 5; i++) wq.push_back(32'hA000_0000 + 32'(i));
    send_queue(wq.size());
    build_msg(esm_control_magic_num, esm_module_id_ad9361, esm_control_message_type_ad9361_write, 3);
    send_queue(wq.size());
    idle(3);
    check("t3_em_cnt", obs_em - b_em, 1);
    check("t3_valid_cnt", obs_valid - b_valid, 3);
    check("t3_err_count", Err_count, 16'd1);
    check("t3_msg_count", Msg_count, 16'd3);

    // Short message ending on pad word.
    mark();
    build_msg(esm_control_magic_num, 8'h00, 8'h00, 0);
    send_queue(wq.size());
    idle(3);
    check("t4_es_cnt", obs_es - b_es, 1);
    check("t4_valid_cnt", obs_valid - b_valid, 0);
    check("t4_err_count", Err_count, 16'd2);

    // Overflow: 260 payload words.
    mark();
    build_msg(esm_control_magic_num, esm_module_id_channelizer, esm_control_message_type_channel_mask, 260);
    send_queue(wq.size());
    idle(3);
    check("t5_valid_cnt", obs_valid - b_valid, 255);
    check("t5_eo_cnt", obs_eo - b_eo, 1);
    check("t5_done_cnt", obs_done - b_done, 0);
    check("t5_last_idx", obs_idx, 8'd254);
    check("t5_err_count", Err_count, 16'd3);

    // Sequence gap on the third message.
    mark();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) next_seq = next_seq + 1;
      build_msg(esm_control_magic_num, esm_module_id_dwell, esm_control_message_type_dwell_entry, 2);
      send_queue(wq.size());
      idle(2);
      check("t6_eseq_cnt", obs_eseq - b_eseq, (SEQ_EN && i == 2) ? 1 : 0);
    end
    check("t6_done_cnt", obs_done - b_done, 3);
    check("t6_err_count", Err_count, SEQ_EN ? 16'd4 : 16'd3);

    // Randomized messages.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] mg;
      mg = esm_control_magic_num;
      if ($urandom_range(0, 7) == 0) mg = $urandom | 32'h1;
      if (mg == esm_control_magic_num && $urandom_range(0, 7) == 0) mg = mg ^ 32'h1;
      if ($urandom_range(0, 5) == 0) next_seq = $urandom;
      gap_en = $urandom_range(0, 1);
      build_msg(mg, 8'($urandom), 8'($urandom), $urandom_range(0, 10));
      if ($urandom_range(0, 9) == 0) wq = wq[0:$urandom_range(0, 3)];
      send_queue(wq.size());
      idle($urandom_range(0, 2));
    end
    gap_en = 0;
    idle(3);

    // Reset in the middle of a payload.
    build_msg(esm_control_magic_num, esm_module_id_dwell, esm_control_message_type_dwell_entry, 20);
    send_queue(8);
    S_axis_valid = 1; S_axis_data = 32'hCAFE_0000;
    S_axis_resetn = 0;
    tick(3);
    check("r_valid", Cfg_valid, 1'b0);
    check("r_data", Cfg_data, 32'h0);
    check("r_msg_count", Msg_count, 16'd0);
    check("r_err_count", Err_count, 16'd0);
    check("r_ready", S_axis_ready, 1'b0);
    S_axis_valid = 0;
    S_axis_resetn = 1;
    tick(2);
    mark();
    next_seq = 32'd77;
    build_msg(esm_control_magic_num, esm_module_id_ad9361, esm_control_message_type_ad9361_write, 2);
    send_queue(wq.size());
    idle(3);
    check("r2_valid_cnt", obs_valid - b_valid, 2);
    check("r2_msg_count", Msg_count, 16'd1);
    check("r2_err_count", Err_count, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
